gb_stream_bridge: RTL

Host-side bus master that turns an 8-bit valid/ready command byte stream (from the UART/USB front end) into single ghostbus transactions on the `gb_*` driver port of the design top. It is the stage directly upstream of the top's ghostbus driver inputs: it drives `gb_addr`/`gb_wdata`/`gb_wen`/`gb_rstb` and consumes `gb_rdata`. Read data and write acks are returned as a response byte stream.

---
 rtl/gb_bridge_pkg.sv | 34 +++
 rtl/gb_resp_ser.sv | 52 +++++
 rtl/gb_stream_bridge.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/gb_bridge_pkg.sv
// gb_bridge_pkg
//   Shared constants and types for the ghostbus stream bridge:
//   command codes, the write-ack byte, FSM state encoding, byte-counter
//   widths and a saturating counter helper.
package gb_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] ACK_BYTE  = 8'hA5;

  // Packet field byte counters: 3 address bytes, 4 data bytes.
  localparam int                BCNT_W    = 2;
  localparam logic [BCNT_W-1:0] ADDR_LAST = 2'd2;
  localparam logic [BCNT_W-1:0] DATA_LAST = 2'd3;

  // Read-latency counter (READ_DELAY up to 15) and response byte counter.
  localparam int WAIT_W = 4;
  localparam int RCNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_READ,
    ST_WAIT,
    ST_RESP
  } bridge_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gb_resp_ser.sv
// gb_resp_ser
//   Response serializer: loads a 32-bit word and emits it MSB byte first
//   on a valid/ready byte stream. len4=1 sends all four bytes, len4=0 sends
//   only the top byte (used for the write ack).
//   Ports:
//     gb_clk, gb_rst_n   clock, async active-low reset
//     load, len4         load strobe and length select (4 bytes / 1 byte)
//     load_data          word to send, MSB byte goes out first
//     out_data/out_valid response byte stream, held while out_ready is low
//     out_ready          downstream accept
//     done               last byte is handshaking this cycle
module gb_resp_ser
  import gb_bridge_pkg::*;
(
  input  logic        gb_clk,
  input  logic        gb_rst_n,
  input  logic        load,
  input  logic        len4,
  input  logic [31:0] load_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done
);

  logic [31:0]       shreg;
  logic [RCNT_W-1:0] remaining;

  // The current byte is always the top of the shift register, so out_data
  // comes straight from a flop and cannot depend on out_ready.
  assign out_data = shreg[31:24];
  assign done     = out_valid & out_ready & (remaining == 3'd1);

  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      shreg     <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      shreg     <= load_data;
      remaining <= len4 ? 3'd4 : 3'd1;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      shreg     <= {shreg[23:0], 8'h00};
      remaining <= remaining - 3'd1;
      if (remaining == 3'd1) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gb_stream_bridge.sv
// gb_stream_bridge
//   Host-side ghostbus master. Parses an 8-bit command stream
//   (cmd, addr[23:0] MSB first, and for writes data[31:0] MSB first),
//   issues exactly one ghostbus strobe per packet and returns read data
//   (4 bytes) or a write ack (0xA5) on the response stream.
//   Ports:
//     gb_clk, gb_rst_n      clock, async active-low reset
//     in_data/in_valid/in_ready     command byte stream
//     out_data/out_valid/out_ready  response byte stream
//     gb_addr, gb_wdata     registered bus address / write data
//     gb_rdata              bus read data, valid READ_DELAY cycles after gb_rstb
//     gb_wen, gb_rstb       one-cycle write / read strobes
//     err_cnt               saturating count of illegal command bytes
module gb_stream_bridge
  import gb_bridge_pkg::*;
#(
  parameter int AW         = 24,
  parameter int DW         = 32,
  parameter int READ_DELAY = 2,
  parameter int ACK_WRITES = 1
) (
  input  logic          gb_clk,
  input  logic          gb_rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  input  logic [DW-1:0] gb_rdata,
  output logic          gb_wen,
  output logic          gb_rstb,
  output logic [7:0]    err_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_DELAY - 1);

  bridge_state_t     state;
  logic [BCNT_W-1:0] byte_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              is_write;

  logic              accept;
  logic              wait_done;
  logic              ser_load;
  logic              ser_len4;
  logic [31:0]       ser_data;
  logic              ser_done;

  assign accept    = in_valid & in_ready;
  assign wait_done = (state == ST_WAIT) && (wait_cnt == WAIT_LAST);

  // The serializer loads on the same edge that leaves WAIT (read data is
  // captured straight into its shift register) or leaves WRITE (ack byte),
  // so the first response byte is valid the very next cycle.
  assign ser_load = wait_done || ((state == ST_WRITE) && (ACK_WRITES != 0));
  assign ser_len4 = (state == ST_WAIT);
  assign ser_data = ser_len4 ? gb_rdata : {ACK_BYTE, 24'h000000};

  // Command FSM. in_ready is registered and set on each transition so it
  // is high exactly in IDLE/ADDR/DATA without any path from in_valid.
  // Address/data are shifted in a byte at a time and otherwise hold.
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      state    <= ST_IDLE;
      byte_cnt <= '0;
      wait_cnt <= '0;
      is_write <= 1'b0;
      in_ready <= 1'b0;
      gb_addr  <= '0;
      gb_wdata <= '0;
      gb_wen   <= 1'b0;
      gb_rstb  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      gb_wen  <= 1'b0;
      gb_rstb <= 1'b0;
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            byte_cnt <= '0;
            if (in_data == CMD_WRITE) begin
              is_write <= 1'b1;
              state    <= ST_ADDR;
            end else if (in_data == CMD_READ) begin
              is_write <= 1'b0;
              state    <= ST_ADDR;
            end else begin
              err_cnt <= sat_inc8(err_cnt);
            end
          end
        end
        ST_ADDR: begin
          if (accept) begin
            gb_addr <= {gb_addr[AW-9:0], in_data};
            if (byte_cnt == ADDR_LAST) begin
              byte_cnt <= '0;
              if (is_write) begin
                state <= ST_DATA;
              end else begin
                state    <= ST_READ;
                gb_rstb  <= 1'b1;
                in_ready <= 1'b0;
              end
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
            gb_wdata <= {gb_wdata[DW-9:0], in_data};
            if (byte_cnt == DATA_LAST) begin
              state    <= ST_WRITE;
              gb_wen   <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        ST_WRITE: begin
          if (ACK_WRITES != 0) begin
            state <= ST_RESP;
          end else begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
          end
        end
        ST_READ: begin
          state    <= ST_WAIT;
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          if (wait_done) begin
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          if (ser_done) begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  gb_resp_ser u_resp_ser (
    .gb_clk    (gb_clk),
    .gb_rst_n  (gb_rst_n),
    .load      (ser_load),
    .len4      (ser_len4),
    .load_data (ser_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (ser_done)
  );

endmodule
